// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for a character LCD bus: writes one byte for the granted
// requester, then polls the busy flag until clear (or the poll limit) before releasing.
module lcd_bus_arbiter #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned EN_CYC    = 12,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned POLL_MAX  = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       done0,
    output logic       done1,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dout,
    output logic       lcd_oe,
    input  logic [7:0] lcd_din,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_EN, W_HOLD, P_SETUP, P_EN, P_HOLD, DONE
    } state_t;

    // Reload values are duration-1 so a phase lasts exactly N cycles ending at count 0.
    localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
    localparam logic [15:0] EN_LD    = 16'(EN_CYC - 1);
    localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);
    localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] poll_q, poll_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        sample_q, sample_d;
    logic        timeout_q, timeout_d;
    logic        phase_end;
    logic        winner;
    logic        unused_din;

    assign unused_din = ^lcd_din[6:0];

    always_comb begin
        state_d   = state_q;
        poll_d    = poll_q;
        rs_d      = rs_q;
        data_d    = data_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        sample_d  = sample_q;
        timeout_d = timeout_q;
        winner    = 1'b0;
        phase_end = (cnt_q == 16'd0);
        cnt_d     = phase_end ? 16'd0 : cnt_q - 16'd1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    winner  = (req0 && req1) ? ~last_q : req1;
                    gnt_d   = winner;
                    rs_d    = winner ? rs1 : rs0;
                    data_d  = winner ? data1 : data0;
                    poll_d  = 16'd0;
                    cnt_d   = SETUP_LD;
                    state_d = W_SETUP;
                end
            end
            W_SETUP: if (phase_end) begin state_d = W_EN;    cnt_d = EN_LD;    end
            W_EN:    if (phase_end) begin state_d = W_HOLD;  cnt_d = HOLD_LD;  end
            W_HOLD:  if (phase_end) begin state_d = P_SETUP; cnt_d = SETUP_LD; end
            P_SETUP: if (phase_end) begin state_d = P_EN;    cnt_d = EN_LD;    end
            P_EN: begin
                if (phase_end) begin
                    sample_d = lcd_din[7];
                    poll_d   = poll_q + 16'd1;
                    cnt_d    = HOLD_LD;
                    state_d  = P_HOLD;
                end
            end
            P_HOLD: begin
                if (phase_end) begin
                    if (!sample_q) begin
                        state_d = DONE;
                    end else if (poll_q >= POLL_LIM) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        cnt_d   = SETUP_LD;
                        state_d = P_SETUP;
                    end
                end
            end
            DONE: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus pins decode straight from the state so a reset edge drops EN immediately.
    always_comb begin
        lcd_oe   = 1'b0;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        lcd_en   = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        case (state_q)
            W_SETUP, W_HOLD: begin lcd_oe = 1'b1; lcd_rs = rs_q; end
            W_EN:            begin lcd_oe = 1'b1; lcd_rs = rs_q; lcd_en = 1'b1; end
            P_SETUP, P_HOLD: lcd_rw = 1'b1;
            P_EN:            begin lcd_rw = 1'b1; lcd_en = 1'b1; end
            DONE:            begin done0 = ~gnt_q; done1 = gnt_q; end
            default:         ;
        endcase
        lcd_dout = lcd_oe ? data_q : 8'h00;
        busy     = (state_q != IDLE);
        timeout  = timeout_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            poll_q    <= 16'd0;
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            sample_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            poll_q    <= poll_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            sample_q  <= sample_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter SETUP_CYC, default 2: clk cycles RS/RW/data are stable before EN rises (legal range 1..65535).
REQ-002 Parameter EN_CYC, default 12: clk cycles EN is held high (legal range 1..65535).
REQ-003 Parameter HOLD_CYC, default 2: clk cycles RS/RW/data are held after EN falls (legal range 1..65535).
REQ-004 Parameter POLL_MAX, default 4095: maximum busy-flag reads per transaction before timeout (legal range 1..65535).
REQ-005 clk  in  1  clock; all logic on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 req0, req1  in  1 each  requester n wants one LCD write; held high until its done pulse.
REQ-008 rs0, rs1  in  1 each  requester n RS value (0 = command, 1 = data).
REQ-009 data0, data1  in  8 each  requester n byte to write.
REQ-010 done0, done1  out  1 each  one-cycle pulse: requester n's write and busy-wait are complete.
REQ-011 lcd_rs, lcd_rw, lcd_en  out  1 each  LCD control pins.
REQ-012 lcd_dout  out  8  LCD write data.
REQ-013 lcd_oe  out  1  1 = drive lcd_dout onto the LCD bus; 0 = bus released.
REQ-014 lcd_din  in  8  LCD bus read-back; bit 7 is the busy flag.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 timeout  out  1  sticky; set when the poll limit is hit; cleared only by reset.

Function
REQ-017 The FSM SHALL have the states IDLE, W_SETUP, W_EN, W_HOLD, P_SETUP, P_EN, P_HOLD and DONE.
REQ-018 In IDLE with any req high, the FSM SHALL grant round-robin: the requester not granted last wins a tie, and after reset req0 wins a tie.
REQ-019 On grant the block SHALL latch the winner's rs and data internally and enter W_SETUP; later changes on the inputs SHALL be ignored.
REQ-020 W_SETUP SHALL last SETUP_CYC cycles with lcd_rw=0, lcd_oe=1, lcd_en=0, lcd_rs=latched rs and lcd_dout=latched data.
REQ-021 W_EN SHALL last EN_CYC cycles with lcd_en=1; W_HOLD SHALL last HOLD_CYC cycles with lcd_en=0; bus values SHALL be unchanged through both states.
REQ-022 P_SETUP SHALL last SETUP_CYC cycles with lcd_oe=0, lcd_rs=0, lcd_rw=1, lcd_en=0.
REQ-023 P_EN SHALL last EN_CYC cycles with lcd_en=1.
REQ-024 lcd_din[7] SHALL be sampled on the last P_EN cycle.
REQ-025 P_HOLD SHALL last HOLD_CYC cycles with lcd_en=0. It SHALL then go to DONE if the sample was 0, otherwise back to P_SETUP.
REQ-026 A 16-bit poll counter SHALL clear on grant and increment on each sample. If the sample is 1 and the count reaches POLL_MAX, the FSM SHALL set timeout and go to DONE anyway.
REQ-027 DONE SHALL last one cycle. It SHALL pulse done of the granted requester, update the last-granted pointer, drive lcd_oe=0, lcd_rw=0 and lcd_en=0, then return to IDLE.
REQ-028 A req arriving during a transaction SHALL wait; no new grant SHALL occur before IDLE. Back-to-back transactions SHALL have exactly one IDLE cycle between them.
REQ-029 Phase durations SHALL be counted by a single 16-bit down-counter reloaded at each state entry, with no off-by-one: EN high width is exactly EN_CYC cycles.
REQ-030 lcd_en SHALL never be high while lcd_oe changes value.
REQ-031 done0 and done1 SHALL never be high in the same cycle.

Reset
REQ-032 While rst=0, on each clk edge: state=IDLE, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_oe=0, lcd_dout=0x00, done0=done1=0, busy=0, timeout=0, last-granted=requester 1 (so req0 wins the first tie), counters=0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no done pulse, and lcd_en=0 from the next edge.

Verification
REQ-034 Single write: req0=1, rs0=1, data0=0x50, lcd_din[7]=0 -> lcd_dout=0x50 with rs=1, rw=0; EN high exactly 12 cycles; one busy poll; done0 pulses once; 2+12+2+2+12+2 clk edges from grant to DONE.
REQ-035 Busy wait: lcd_din[7]=1 for the first 3 polls, then 0 -> exactly 4 EN pulses in the poll phase, done0 pulses, timeout stays 0.
REQ-036 Tie: req0=req1=1 from reset -> req0 is served first, then req1 after one IDLE cycle; with both held high, grants alternate 0,1,0,1.
REQ-037 Timeout: POLL_MAX=3, lcd_din[7] stuck at 1 -> 3 polls, timeout=1, done pulses, next transaction proceeds normally with timeout still 1.
REQ-038 Reset mid-W_EN: rst=0 for one cycle -> lcd_en=0, busy=0, no done pulse; a subsequent req1 is granted normally.
REQ-039 Data capture: change data0 to 0xFF one cycle after grant -> lcd_dout stays at the originally latched byte.
